// File: rtl/pixel_buf_ctrl_if.sv
// Shared bus between the SPI front end, the inference engine and the pixel buffer controller.
// The master modport is the surrounding system; the slave modport is the controller.
interface pixel_buf_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              shift_SPI;
    logic [7:0]        SPI_in;
    logic              write_en;
    logic              nn_start;
    logic              nn_rd_req;
    logic [ADDR_W-1:0] nn_rd_addr;
    logic              nn_done;
    logic              nn_rd_grant;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_wen;
    logic              mem_ren;
    logic              frame_ready;
    logic              busy;
    logic              overrun;

    modport master (
        output shift_SPI, SPI_in, write_en, nn_start, nn_rd_req, nn_rd_addr, nn_done,
        input  nn_rd_grant, mem_addr, mem_wdata, mem_wen, mem_ren, frame_ready, busy, overrun
    );

    modport slave (
        input  shift_SPI, SPI_in, write_en, nn_start, nn_rd_req, nn_rd_addr, nn_done,
        output nn_rd_grant, mem_addr, mem_wdata, mem_wen, mem_ren, frame_ready, busy, overrun
    );
endinterface

// File: rtl/pixel_buf_ctrl.sv
// Pixel buffer SRAM controller: loads SPI frames, then lends the port to the inference engine.
// Optional macro PIX_BINARIZE_EN thresholds every written pixel to 8'h00 / 8'hFF.
module pixel_buf_ctrl #(
    parameter int NUM_PIX = 784,
    parameter int ADDR_W  = 10,
    parameter int THRESH  = 128
) (
    input  logic             clk,
    input  logic             n_rst,
    pixel_buf_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        READY   = 2'd2,
        COMPUTE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we_q;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_wen;
    logic              r_mem_ren;
    logic              r_overrun;

    logic              w_rise;
    logic              w_wr_fire;
    logic              w_rd_fire;
    logic              w_ptr_clr;
    logic              w_ovr_set;

    function automatic logic [7:0] pix_data(input logic [7:0] b);
`ifdef PIX_BINARIZE_EN
        return (int'(b) >= THRESH) ? 8'hFF : 8'h00;
`else
        return b;
`endif
    endfunction

    assign w_rise = bus.write_en & ~r_we_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Write and read fire only from their owning state, so the port can never see both at once
    always_comb begin
        w_state_nxt = r_state;
        w_wr_fire   = 1'b0;
        w_rd_fire   = 1'b0;
        w_ptr_clr   = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = LOAD;
                    w_ptr_clr   = 1'b1;
                end
            end
            LOAD: begin
                if (!bus.write_en) begin
                    w_state_nxt = IDLE;
                end else if (bus.shift_SPI) begin
                    w_wr_fire = 1'b1;
                    if (r_wr_ptr == LAST_PIX) begin
                        w_state_nxt = READY;
                    end
                end
            end
            READY: begin
                if (bus.nn_start) begin
                    w_state_nxt = COMPUTE;
                end else if (w_rise) begin
                    w_state_nxt = LOAD;
                    w_ptr_clr   = 1'b1;
                end
            end
            COMPUTE: begin
                w_rd_fire = bus.nn_rd_req;
                w_ovr_set = bus.shift_SPI;
                if (bus.nn_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_we_q      <= 1'b0;
            r_wr_ptr    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_we_q    <= bus.write_en;
            r_mem_wen <= w_wr_fire;
            r_mem_ren <= w_rd_fire;
            if (w_wr_fire) begin
                r_mem_addr  <= r_wr_ptr;
                r_mem_wdata <= pix_data(bus.SPI_in);
            end else if (w_rd_fire) begin
                r_mem_addr  <= bus.nn_rd_addr;
            end
            // Pointer parks on the last pixel; the next frame always restarts it from zero
            if (w_ptr_clr) begin
                r_wr_ptr <= '0;
            end else if (w_wr_fire && (r_wr_ptr != LAST_PIX)) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.nn_rd_grant = w_rd_fire;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_wen     = r_mem_wen;
    assign bus.mem_ren     = r_mem_ren;
    assign bus.frame_ready = (r_state == READY) || (r_state == COMPUTE);
    assign bus.busy        = (r_state == LOAD) || (r_state == COMPUTE);
    assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_pixel_buf_ctrl.sv
// Directed bench for pixel_buf_ctrl with a 4-pixel frame.
module tb_pixel_buf_ctrl;
    localparam int ADDR_W = 10;

    logic clk;
    logic n_rst;
    int   n_checks;
    int   n_fail;

    pixel_buf_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_buf_ctrl #(
        .NUM_PIX (4),
        .ADDR_W  (ADDR_W),
        .THRESH  (128)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_wdata(input logic [7:0] b);
`ifdef PIX_BINARIZE_EN
        return (b >= 8'h80) ? 8'hFF : 8'h00;
`else
        return b;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.shift_SPI = 1'b1;
        bus.SPI_in    = b;
        tick();
        bus.shift_SPI = 1'b0;
    endtask

    task automatic start_load();
        bus.write_en = 1'b0;
        tick();
        bus.write_en = 1'b1;
        tick();
    endtask

    task automatic load_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        start_load();
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.nn_rd_req = 1'b1;
        #3;
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_en: wen=%b ren=%b expected 0 0", bus.mem_wen, bus.mem_ren); end
        n_checks++; if (bus.mem_addr !== 10'd0 || bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_data: addr=%0d wdata=%h expected 0 00", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.frame_ready !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_status: fr=%b busy=%b ovr=%b expected 0 0 0", bus.frame_ready, bus.busy, bus.overrun); end
        n_checks++; if (bus.nn_rd_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 0", bus.nn_rd_grant); end
        tick();
        tick();
        n_rst = 1'b1;
        bus.nn_rd_req = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        logic [7:0] bytes [4];
        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        start_load();
        n_checks++; if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL load_entry: busy=%b fr=%b expected 1 0", bus.busy, bus.frame_ready); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL early_ready[%0d]: got %b expected 0", i, bus.frame_ready); end
            send_byte(bytes[i]);
            n_checks++;
            if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 10'(i) || bus.mem_wdata !== exp_wdata(bytes[i])) begin
                n_fail++;
                $display("FAIL frame_write[%0d]: wen=%b addr=%0d data=%h expected 1 %0d %h", i, bus.mem_wen, bus.mem_addr, bus.mem_wdata, i, exp_wdata(bytes[i]));
            end
        end
        n_checks++; if (bus.frame_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL frame_ready: fr=%b busy=%b expected 1 0", bus.frame_ready, bus.busy); end
        tick();
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 10'd3) begin n_fail++; $display("FAIL wen_pulse: wen=%b addr=%0d expected 0 3", bus.mem_wen, bus.mem_addr); end
        bus.nn_rd_req = 1'b1;
        #1;
        n_checks++; if (bus.nn_rd_grant !== 1'b0) begin n_fail++; $display("FAIL ready_grant: got %b expected 0", bus.nn_rd_grant); end
        bus.nn_rd_req = 1'b0;
        send_byte(8'hEE);
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ready_shift: wen=%b ovr=%b expected 0 0", bus.mem_wen, bus.overrun); end
    endtask

    task automatic test_inference();
        bus.nn_start = 1'b1;
        tick();
        bus.nn_start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL compute_entry: busy=%b fr=%b expected 1 1", bus.busy, bus.frame_ready); end
        bus.nn_rd_req  = 1'b1;
        bus.nn_rd_addr = 10'd2;
        #1;
        n_checks++; if (bus.nn_rd_grant !== 1'b1) begin n_fail++; $display("FAIL grant: got %b expected 1", bus.nn_rd_grant); end
        tick();
        bus.nn_rd_req = 1'b0;
        n_checks++; if (bus.mem_ren !== 1'b1 || bus.mem_addr !== 10'd2 || bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL read_issue: ren=%b addr=%0d wen=%b expected 1 2 0", bus.mem_ren, bus.mem_addr, bus.mem_wen); end
        tick();
        n_checks++; if (bus.mem_ren !== 1'b0 || bus.mem_addr !== 10'd2) begin n_fail++; $display("FAIL ren_pulse: ren=%b addr=%0d expected 0 2", bus.mem_ren, bus.mem_addr); end
        bus.nn_done = 1'b1;
        tick();
        bus.nn_done = 1'b0;
        n_checks++; if (bus.frame_ready !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL done: fr=%b busy=%b expected 0 0", bus.frame_ready, bus.busy); end
        bus.nn_rd_req = 1'b1;
        #1;
        n_checks++; if (bus.nn_rd_grant !== 1'b0) begin n_fail++; $display("FAIL idle_grant: got %b expected 0", bus.nn_rd_grant); end
        bus.nn_rd_req = 1'b0;
    endtask

    task automatic test_short_frame();
        start_load();
        send_byte(8'hA1);
        send_byte(8'hA2);
        n_checks++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 10'd1 || bus.mem_wdata !== exp_wdata(8'hA2)) begin n_fail++; $display("FAIL short_write: wen=%b addr=%0d data=%h expected 1 1 %h", bus.mem_wen, bus.mem_addr, bus.mem_wdata, exp_wdata(8'hA2)); end
        bus.write_en = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL abort: busy=%b fr=%b expected 0 0", bus.busy, bus.frame_ready); end
        send_byte(8'hA3);
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 10'd1) begin n_fail++; $display("FAIL post_abort: wen=%b addr=%0d expected 0 1", bus.mem_wen, bus.mem_addr); end
    endtask

    task automatic test_data_patterns();
        logic [7:0] bytes [4];
        bytes = '{8'h7F, 8'h80, 8'hFF, 8'h00};
        start_load();
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i]);
            n_checks++;
            if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 10'(i) || bus.mem_wdata !== exp_wdata(bytes[i])) begin
                n_fail++;
                $display("FAIL pattern[%0d]: wen=%b addr=%0d data=%h expected 1 %0d %h", i, bus.mem_wen, bus.mem_addr, bus.mem_wdata, i, exp_wdata(bytes[i]));
            end
        end
        n_checks++; if (bus.frame_ready !== 1'b1) begin n_fail++; $display("FAIL pattern_ready: got %b expected 1", bus.frame_ready); end
    endtask

    task automatic test_lockout();
        bus.nn_start = 1'b1;
        tick();
        bus.nn_start = 1'b0;
        send_byte(8'h55);
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.overrun !== 1'b1) begin n_fail++; $display("FAIL lockout: wen=%b ovr=%b expected 0 1", bus.mem_wen, bus.overrun); end
        n_checks++; if (bus.mem_wdata !== exp_wdata(8'h00)) begin n_fail++; $display("FAIL lockout_data: got %h expected %h", bus.mem_wdata, exp_wdata(8'h00)); end
        bus.nn_done = 1'b1;
        tick();
        bus.nn_done = 1'b0;
        tick();
        n_checks++; if (bus.overrun !== 1'b1 || bus.frame_ready !== 1'b0) begin n_fail++; $display("FAIL overrun_sticky: ovr=%b fr=%b expected 1 0", bus.overrun, bus.frame_ready); end
        bus.write_en = 1'b0;
        n_rst = 1'b0;
        #2;
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", bus.overrun); end
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_restart_collision();
        load_frame(8'h01, 8'h02, 8'h03, 8'h04);
        bus.write_en = 1'b0;
        tick();
        bus.write_en = 1'b1;
        bus.nn_start = 1'b1;
        tick();
        bus.nn_start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.frame_ready !== 1'b1 || bus.mem_wen !== 1'b0) begin n_fail++; $display("FAIL collision: busy=%b fr=%b wen=%b expected 1 1 0", bus.busy, bus.frame_ready, bus.mem_wen); end
        bus.nn_done = 1'b1;
        tick();
        bus.nn_done = 1'b0;
        load_frame(8'h11, 8'h12, 8'h13, 8'h14);
        bus.write_en = 1'b0;
        tick();
        bus.write_en = 1'b1;
        tick();
        n_checks++; if (bus.frame_ready !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart: fr=%b busy=%b expected 0 1", bus.frame_ready, bus.busy); end
        send_byte(8'h99);
        n_checks++; if (bus.mem_wen !== 1'b1 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== exp_wdata(8'h99)) begin n_fail++; $display("FAIL restart_ptr: wen=%b addr=%0d data=%h expected 1 0 %h", bus.mem_wen, bus.mem_addr, bus.mem_wdata, exp_wdata(8'h99)); end
        bus.write_en = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        start_load();
        send_byte(8'hAA);
        n_checks++; if (bus.mem_wen !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL preload: wen=%b busy=%b expected 1 1", bus.mem_wen, bus.busy); end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++; if (bus.mem_wen !== 1'b0 || bus.mem_addr !== 10'd0 || bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL async_reset_mem: wen=%b addr=%0d data=%h expected 0 0 00", bus.mem_wen, bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (bus.busy !== 1'b0 || bus.frame_ready !== 1'b0 || bus.mem_ren !== 1'b0) begin n_fail++; $display("FAIL async_reset_status: busy=%b fr=%b ren=%b expected 0 0 0", bus.busy, bus.frame_ready, bus.mem_ren); end
        bus.write_en = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        n_rst          = 1'b0;
        bus.shift_SPI  = 1'b0;
        bus.SPI_in     = 8'h00;
        bus.write_en   = 1'b0;
        bus.nn_start   = 1'b0;
        bus.nn_rd_req  = 1'b0;
        bus.nn_rd_addr = '0;
        bus.nn_done    = 1'b0;
        test_reset();
        test_full_frame();
        test_inference();
        test_short_frame();
        test_data_patterns();
        test_lockout();
        test_restart_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
